cart_mapper: RTL
================

CART_MAPPER -- requirements
Module: cart_mapper

Interface
REQ-001 SHALL have parameter ROM_AW, default 15; ROM address width in bits (32 KB).
REQ-002 SHALL have parameter SC_AW, default 7; cartridge (Superchip) RAM address width in bits (128 B).
REQ-003 SHALL have port clk_sys  in  1  system clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_ena  in  1  one-cycle strobe marking the valid bus cycle.
REQ-006 SHALL have port cpu_addr  in  13  CPU address A12..A0.
REQ-007 SHALL have port cpu_rnw  in  1  1 = read, 0 = write.
REQ-008 SHALL have port sc_en  in  1  Superchip RAM enable.
REQ-009 SHALL have port mode_ovr  in  3  0 = auto-detect, otherwise forced mapper code.
REQ-010 SHALL have port load_we  in  1  loader ROM write strobe.
REQ-011 SHALL have port load_addr  in  ROM_AW  loader byte address.
REQ-012 SHALL have port rom_addr  out  ROM_AW  banked ROM address.
REQ-013 SHALL have port sc_rd  out  1  Superchip read-window hit.
REQ-014 SHALL have port sc_we  out  1  Superchip write strobe.
REQ-015 SHALL have port sc_addr  out  SC_AW  Superchip RAM address, equal to cpu_addr[SC_AW-1:0].
REQ-016 SHALL have port mapper  out  3  active mapper code.
REQ-017 SHALL have port bank  out  3  current bank; under E0, the segment-0 bank.

Function
REQ-018 Mapper codes SHALL be: 0 = NONE4K, 1 = NONE2K, 2 = F8 (8K), 3 = F6 (16K), 4 = F4 (32K), 5 = E0 (8K, 1K slices).
REQ-019 On load_we with load_addr == 0, the size tracker SHALL clear its max-address register to 0.
REQ-020 On every other load_we, the tracker SHALL set max <= max(max, load_addr).
REQ-021 Auto mapper SHALL be registered one cycle after load_we, from max: <0x800 -> 1, <0x1000 -> 0, <0x2000 -> 2, <0x4000 -> 3, else 4.
REQ-022 mapper SHALL equal mode_ovr when mode_ovr is nonzero, otherwise the auto value, combinationally.
REQ-023 Hotspot actions SHALL take effect only when cpu_ena = 1 and cpu_addr[12] = 1, on reads and writes alike.
REQ-024 Bank registers SHALL update on the clock edge ending the hotspot cycle; rom_addr reflects the new bank from the following cycle.
REQ-025 F8 hotspots SHALL be 0x1FF8..0x1FF9, selecting bank = addr - 0x1FF8.
REQ-026 F6 hotspots SHALL be 0x1FF6..0x1FF9, selecting bank = addr - 0x1FF6.
REQ-027 F4 hotspots SHALL be 0x1FF4..0x1FFB, selecting bank = addr - 0x1FF4.
REQ-028 E0 hotspots SHALL be 0x1FE0..0x1FE7 setting seg0, 0x1FE8..0x1FEF setting seg1, 0x1FF0..0x1FF7 setting seg2, each to addr[2:0]; seg3 is fixed at 7.
REQ-029 NONE4K and NONE2K SHALL have no hotspots.
REQ-030 rom_addr SHALL be combinational, with unused upper bits 0: NONE2K {addr[10:0]}; NONE4K {addr[11:0]}; F8, F6 and F4 {bank, addr[11:0]}; E0 {seg[addr[11:10]], addr[9:0]}.
REQ-031 Bank values beyond the mapper's range SHALL be masked to the mapper's bank-count width.
REQ-032 Superchip SHALL be active only when sc_en = 1 and mapper is one of {2, 3, 4}.
REQ-033 Superchip write window SHALL be 0x1000..0x107F: sc_we = cpu_ena & hit & ~cpu_rnw.
REQ-034 Superchip read window SHALL be 0x1080..0x10FF: sc_rd = hit (combinational, independent of cpu_ena).
REQ-035 A Superchip window access SHALL never act as a hotspot.
REQ-036 A change of mapper code (load or mode_ovr) SHALL reset the bank registers in the next cycle, as REQ-038.

Reset
REQ-037 reset SHALL take priority over hotspot updates in the same cycle.
REQ-038 On reset: bank <= last bank of the mapper (F8 = 1, F6 = 3, F4 = 7, otherwise 0); E0 seg0..2 <= 4, 5, 6.
REQ-039 reset SHALL NOT clear the size tracker or the auto mapper; loads complete while the CPU is held in reset.
REQ-040 Outputs during reset SHALL be: sc_we = 0; rom_addr follows the reset bank values.

Configuration
REQ-041 Macro CART_MAPPER_E0_EN SHALL compile in E0 support (segment registers, E0 hotspots and E0 rom_addr path).
REQ-042 Without CART_MAPPER_E0_EN, mapper code 5 SHALL be treated as NONE4K, and no segment registers SHALL exist.

Structure
REQ-043 Package cart_pkg SHALL hold the mapper-code enum typedef, the hotspot base constants (0x1FF8, 0x1FF6, 0x1FF4, 0x1FE0) and the Superchip window constants.
REQ-044 Sub-module cart_size_detect SHALL contain the max-address tracker and the auto-mapper register.

Verification
REQ-045 Bench SHALL cover: load 0x0000..0x1FFF, reset -> mapper = 2, bank = 1; read 0x1FF8 with cpu_ena -> next cycle rom_addr for 0x1123 = 0x0123.
REQ-046 Bench SHALL cover: load 16K, sc_en = 1, write 0x55 to 0x1005 -> sc_we = 1, sc_addr = 0x05; read 0x1085 -> sc_rd = 1, no bank change.
REQ-047 Bench SHALL cover: F4, access 0x1FFB -> bank = 7; access 0x1FF4 with reset asserted the same cycle -> bank = 7 (reset wins).
REQ-048 Bench SHALL cover: mode_ovr = 5 (CART_MAPPER_E0_EN defined), access 0x1FE2 then 0x1FF5 -> cpu 0x1000 maps to 0x0800, cpu 0x1800 to 0x1400, cpu 0x1C00 to 0x1C00.
REQ-049 Bench SHALL cover: load 2K -> mapper = 1, cpu 0x1FFF maps to 0x07FF; hotspot 0x1FF8 is ignored.
REQ-050 Bench SHALL cover: hotspot address with cpu_ena = 0 -> no bank change.

Source files
------------

// File: rtl/cart_pkg.sv
// Cartridge mapper shared definitions: mapper codes, hotspot bases,
// Superchip window limits and small helper functions.
package cart_pkg;

   typedef enum logic [2:0] {
      MAP_NONE4K = 3'd0,
      MAP_NONE2K = 3'd1,
      MAP_F8     = 3'd2,
      MAP_F6     = 3'd3,
      MAP_F4     = 3'd4,
      MAP_E0     = 3'd5
   } mapper_e;

   // Hotspot base addresses (CPU A12..A0)
   localparam logic [12:0] HS_F8 = 13'h1FF8;
   localparam logic [12:0] HS_F6 = 13'h1FF6;
   localparam logic [12:0] HS_F4 = 13'h1FF4;
   localparam logic [12:0] HS_E0 = 13'h1FE0;

   // Superchip windows: writes low half, reads high half
   localparam logic [12:0] SC_WR_LO = 13'h1000;
   localparam logic [12:0] SC_WR_HI = 13'h107F;
   localparam logic [12:0] SC_RD_LO = 13'h1080;
   localparam logic [12:0] SC_RD_HI = 13'h10FF;

   // Image size (highest loaded byte address) to auto-detected mapper
   function automatic logic [2:0] size_to_map(input logic [31:0] max_addr);
      if (max_addr < 32'h0800)      return 3'(MAP_NONE2K);
      else if (max_addr < 32'h1000) return 3'(MAP_NONE4K);
      else if (max_addr < 32'h2000) return 3'(MAP_F8);
      else if (max_addr < 32'h4000) return 3'(MAP_F6);
      else                          return 3'(MAP_F4);
   endfunction

   // Power-on bank: the last bank of the mapper
   function automatic logic [2:0] reset_bank(input mapper_e m);
      case (m)
         MAP_F8:  return 3'd1;
         MAP_F6:  return 3'd3;
         MAP_F4:  return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/cart_size_detect.sv
// Tracks the highest byte address written by the loader and registers the
// auto-detected mapper code from it. Not reset: loads happen while the CPU
// side is held in reset.
//   clk_sys   in   system clock
//   load_we   in   loader write strobe
//   load_addr in   loader byte address (address 0 restarts tracking)
//   auto_map  out  registered auto-detected mapper code
module cart_size_detect
   import cart_pkg::*;
#(
   parameter int unsigned ROM_AW = 15
) (
   input  logic              clk_sys,
   input  logic              load_we,
   input  logic [ROM_AW-1:0] load_addr,
   output logic [2:0]        auto_map
);

   logic [ROM_AW-1:0] max_q, max_d;
   logic [2:0]        auto_q, auto_d;

   // Max-address tracker; mapper is decoded from the updated max
   always_comb begin
      max_d  = max_q;
      auto_d = auto_q;
      if (load_we) begin
         if (load_addr == '0)
            max_d = '0;
         else if (load_addr > max_q)
            max_d = load_addr;
         auto_d = size_to_map(32'(max_d));
      end
   end

   always_ff @(posedge clk_sys) begin
      max_q  <= max_d;
      auto_q <= auto_d;
   end

   assign auto_map = auto_q;

endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank-switching mapper (NONE2K/NONE4K/F8/F6/F4, optional E0)
// with Superchip RAM window decode.
// Optional feature macro: CART_MAPPER_E0_EN compiles in E0 (1K slices).
//   clk_sys, reset          clock, synchronous active-high reset
//   cpu_ena/addr/rnw        CPU bus cycle strobe, A12..A0, direction
//   sc_en                   Superchip RAM enable
//   mode_ovr                0 = auto-detect, else forced mapper code
//   load_we/load_addr       loader writes (feed size detection)
//   rom_addr                banked ROM address (combinational)
//   sc_rd/sc_we/sc_addr     Superchip read hit, write strobe, RAM address
//   mapper, bank            active mapper code, current (seg-0) bank
module cart_mapper
   import cart_pkg::*;
#(
   parameter int unsigned ROM_AW = 15,
   parameter int unsigned SC_AW  = 7
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cpu_ena,
   input  logic [12:0]       cpu_addr,
   input  logic              cpu_rnw,
   input  logic              sc_en,
   input  logic [2:0]        mode_ovr,
   input  logic              load_we,
   input  logic [ROM_AW-1:0] load_addr,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              sc_rd,
   output logic              sc_we,
   output logic [SC_AW-1:0]  sc_addr,
   output logic [2:0]        mapper,
   output logic [2:0]        bank
);

   logic [2:0] auto_map;
   logic [2:0] map_raw;
   mapper_e    map_e, map_prev_q;
   logic [2:0] bank_q, bank_d, bank_m;
   logic       sc_act, sc_wr_hit, sc_rd_hit, hs_cycle;
   logic [31:0] rom_w;
`ifdef CART_MAPPER_E0_EN
   logic [2:0] seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg_sel;
`endif

   cart_size_detect #(.ROM_AW(ROM_AW)) u_size (
      .clk_sys  (clk_sys),
      .load_we  (load_we),
      .load_addr(load_addr),
      .auto_map (auto_map)
   );

   // Effective mapper; unsupported codes fall back to NONE4K
   always_comb begin
      map_raw = (mode_ovr != 3'd0) ? mode_ovr : auto_map;
      map_e   = MAP_NONE4K;
      case (map_raw)
         3'd1:    map_e = MAP_NONE2K;
         3'd2:    map_e = MAP_F8;
         3'd3:    map_e = MAP_F6;
         3'd4:    map_e = MAP_F4;
`ifdef CART_MAPPER_E0_EN
         3'd5:    map_e = MAP_E0;
`endif
         default: map_e = MAP_NONE4K;
      endcase
   end

   assign mapper = 3'(map_e);

   // Superchip decode; a window hit suppresses hotspot handling
   assign sc_act    = sc_en && (map_e == MAP_F8 || map_e == MAP_F6 || map_e == MAP_F4);
   assign sc_wr_hit = sc_act && cpu_addr >= SC_WR_LO && cpu_addr <= SC_WR_HI;
   assign sc_rd_hit = sc_act && cpu_addr >= SC_RD_LO && cpu_addr <= SC_RD_HI;
   assign sc_rd     = sc_rd_hit;
   assign sc_we     = cpu_ena && sc_wr_hit && !cpu_rnw && !reset;
   assign sc_addr   = cpu_addr[SC_AW-1:0];
   assign hs_cycle  = cpu_ena && cpu_addr[12] && !sc_wr_hit && !sc_rd_hit;

   // Bank next-state: reset, then mapper change, then hotspot
   always_comb begin
      bank_d = bank_q;
`ifdef CART_MAPPER_E0_EN
      seg0_d = seg0_q;
      seg1_d = seg1_q;
      seg2_d = seg2_q;
`endif
      if (reset || map_e != map_prev_q) begin
         bank_d = reset_bank(map_e);
`ifdef CART_MAPPER_E0_EN
         seg0_d = 3'd4;
         seg1_d = 3'd5;
         seg2_d = 3'd6;
`endif
      end else if (hs_cycle) begin
         case (map_e)
            MAP_F8:
               if (cpu_addr >= HS_F8 && cpu_addr <= HS_F8 + 13'd1)
                  bank_d = 3'(cpu_addr - HS_F8);
            MAP_F6:
               if (cpu_addr >= HS_F6 && cpu_addr <= HS_F6 + 13'd3)
                  bank_d = 3'(cpu_addr - HS_F6);
            MAP_F4:
               if (cpu_addr >= HS_F4 && cpu_addr <= HS_F4 + 13'd7)
                  bank_d = 3'(cpu_addr - HS_F4);
`ifdef CART_MAPPER_E0_EN
            MAP_E0: begin
               if (cpu_addr >= HS_E0 && cpu_addr <= HS_E0 + 13'd7)
                  seg0_d = cpu_addr[2:0];
               else if (cpu_addr >= HS_E0 + 13'd8 && cpu_addr <= HS_E0 + 13'd15)
                  seg1_d = cpu_addr[2:0];
               else if (cpu_addr >= HS_E0 + 13'd16 && cpu_addr <= HS_E0 + 13'd23)
                  seg2_d = cpu_addr[2:0];
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      map_prev_q <= map_e;
      bank_q     <= bank_d;
`ifdef CART_MAPPER_E0_EN
      seg0_q     <= seg0_d;
      seg1_q     <= seg1_d;
      seg2_q     <= seg2_d;
`endif
   end

   // Bank masked to the mapper's bank-count width
   always_comb begin
      case (map_e)
         MAP_F8:  bank_m = {2'b00, bank_q[0]};
         MAP_F6:  bank_m = {1'b0, bank_q[1:0]};
         MAP_F4:  bank_m = bank_q;
         default: bank_m = 3'd0;
      endcase
   end

`ifdef CART_MAPPER_E0_EN
   always_comb begin
      case (cpu_addr[11:10])
         2'd0:    seg_sel = seg0_q;
         2'd1:    seg_sel = seg1_q;
         2'd2:    seg_sel = seg2_q;
         default: seg_sel = 3'd7;
      endcase
   end
   assign bank = (map_e == MAP_E0) ? seg0_q : bank_m;
`else
   assign bank = bank_m;
`endif

   // Banked ROM address, unused upper bits zero
   always_comb begin
      case (map_e)
         MAP_NONE2K:                rom_w = {21'd0, cpu_addr[10:0]};
         MAP_F8, MAP_F6, MAP_F4:    rom_w = {17'd0, bank_m, cpu_addr[11:0]};
`ifdef CART_MAPPER_E0_EN
         MAP_E0:                    rom_w = {19'd0, seg_sel, cpu_addr[9:0]};
`endif
         default:                   rom_w = {20'd0, cpu_addr[11:0]};
      endcase
   end

   assign rom_addr = ROM_AW'(rom_w);

endmodule
